// File: rtl/alu_operand_fetch.sv
// Operand capture stage ahead of the ALU: builds two 16-bit operands from registers and bus immediates.
// Define OPFETCH_SEXT_EN to make mode 11 sign-extend its byte; otherwise mode 11 matches mode 01.
module alu_operand_fetch #(
  parameter int IMM_TIMEOUT = 8
) (
  input  logic        core_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [15:0] reg_a,
  input  logic [15:0] reg_b,
  input  logic [7:0]  data_bus,
  input  logic        bus_valid,
  output logic [15:0] ALU_input0,
  output logic [15:0] ALU_input1,
  output logic        operands_valid,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI} state_t;

  localparam logic [7:0] TMR_LAST = 8'(IMM_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [1:0]  mode_q, mode_nxt;
  logic [7:0]  lo_q, lo_nxt;
  logic [7:0]  tmr, tmr_nxt;
  logic [15:0] in0_nxt, in1_nxt;
  logic        ov_nxt, te_nxt;

  function automatic logic [15:0] zext_imm8(input logic [7:0] b);
    return {8'h00, b};
  endfunction

  function automatic logic [15:0] sext_imm8(input logic [7:0] b);
`ifdef OPFETCH_SEXT_EN
    logic signed [7:0] sb;
    sb = signed'(b);
    return 16'(sb);
`else
    return {8'h00, b};
`endif
  endfunction

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    lo_nxt    = lo_q;
    tmr_nxt   = tmr;
    in0_nxt   = ALU_input0;
    in1_nxt   = ALU_input1;
    ov_nxt    = 1'b0;
    te_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          in0_nxt  = reg_a;
          mode_nxt = mode;
          if (mode == 2'b00) begin
            in1_nxt = reg_b;
            ov_nxt  = 1'b1;
          end else begin
            state_nxt = WAIT_LO;
            tmr_nxt   = 8'd0;
          end
        end
      end
      WAIT_LO: begin
        if (bus_valid) begin
          case (mode_q)
            2'b10: begin
              lo_nxt    = data_bus;
              tmr_nxt   = 8'd0;
              state_nxt = WAIT_HI;
            end
            2'b11: begin
              in1_nxt   = sext_imm8(data_bus);
              ov_nxt    = 1'b1;
              state_nxt = IDLE;
            end
            default: begin
              in1_nxt   = zext_imm8(data_bus);
              ov_nxt    = 1'b1;
              state_nxt = IDLE;
            end
          endcase
        end
      end
      WAIT_HI: begin
        if (bus_valid) begin
          in1_nxt   = {data_bus, lo_q};
          ov_nxt    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Watchdog: a byte on the threshold edge is taken above and never reaches this branch.
    if (state != IDLE && !bus_valid) begin
      if (tmr == TMR_LAST) begin
        state_nxt = IDLE;
        te_nxt    = 1'b1;
        tmr_nxt   = 8'd0;
      end else begin
        tmr_nxt = tmr + 8'd1;
      end
    end
  end

  always_ff @(posedge core_clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      mode_q         <= 2'b00;
      lo_q           <= 8'h00;
      tmr            <= 8'h00;
      ALU_input0     <= 16'h0000;
      ALU_input1     <= 16'h0000;
      operands_valid <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      state          <= state_nxt;
      mode_q         <= mode_nxt;
      lo_q           <= lo_nxt;
      tmr            <= tmr_nxt;
      ALU_input0     <= in0_nxt;
      ALU_input1     <= in1_nxt;
      operands_valid <= ov_nxt;
      timeout_err    <= te_nxt;
    end
  end

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Scoreboard bench for alu_operand_fetch: directed captures queue expected pulses, a monitor checks them.
module tb_alu_operand_fetch;

  logic        core_clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] reg_a, reg_b;
  logic [7:0]  data_bus;
  logic        bus_valid;
  logic [15:0] ALU_input0, ALU_input1;
  logic        operands_valid, busy, timeout_err;

  alu_operand_fetch #(.IMM_TIMEOUT(8)) dut (
    .core_clk(core_clk), .reset_n(reset_n), .start(start), .mode(mode),
    .reg_a(reg_a), .reg_b(reg_b), .data_bus(data_bus), .bus_valid(bus_valid),
    .ALU_input0(ALU_input0), .ALU_input1(ALU_input1),
    .operands_valid(operands_valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 core_clk = ~core_clk;

`ifdef OPFETCH_SEXT_EN
  localparam logic [15:0] EXP_FE = 16'hFFFE;
`else
  localparam logic [15:0] EXP_FE = 16'h00FE;
`endif

  typedef struct {
    bit          is_err;
    logic [15:0] a0;
    logic [15:0] a1;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic push_v(input logic [15:0] a0, input logic [15:0] a1);
    exp_t e;
    e.is_err = 1'b0; e.a0 = a0; e.a1 = a1;
    q.push_back(e);
  endtask

  task automatic push_e(input logic [15:0] a0, input logic [15:0] a1);
    exp_t e;
    e.is_err = 1'b1; e.a0 = a0; e.a1 = a1;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
    start = 1'b1; mode = m; reg_a = a; reg_b = b;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_valid = 1'b1; data_bus = b;
    tick();
    bus_valid = 1'b0;
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge core_clk) begin
    if (operands_valid || timeout_err) begin
      exp_t e;
      chk("exclusive_pulse", {15'd0, operands_valid & timeout_err}, 16'd0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", {14'd0, timeout_err, operands_valid}, 16'd0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind_err", {15'd0, timeout_err}, {15'd0, e.is_err});
        chk("pulse_kind_valid", {15'd0, operands_valid}, {15'd0, ~e.is_err});
        chk("alu_input0", ALU_input0, e.a0);
        chk("alu_input1", ALU_input1, e.a1);
      end
    end
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; mode = 2'b00; reg_a = 16'h0; reg_b = 16'h0;
    data_bus = 8'h00; bus_valid = 1'b0;
    tick(); tick();
    chk("rst_in0", ALU_input0, 16'h0000);
    chk("rst_in1", ALU_input1, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_ov", {15'd0, operands_valid}, 16'd0);
    chk("rst_te", {15'd0, timeout_err}, 16'd0);
    reset_n = 1'b1;
    tick();

    // reg-reg: single-cycle valid, busy never rises
    push_v(16'h1234, 16'h00FF);
    do_start(2'b00, 16'h1234, 16'h00FF);
    chk("rr_busy", {15'd0, busy}, 16'd0);
    chk("rr_ov", {15'd0, operands_valid}, 16'd1);
    tick();
    chk("rr_ov_drop", {15'd0, operands_valid}, 16'd0);

    // imm16 with idle gaps
    do_start(2'b10, 16'hC000, 16'h0);
    chk("i16_busy0", {15'd0, busy}, 16'd1);
    tick(); tick();
    send_byte(8'h34);
    chk("i16_busy1", {15'd0, busy}, 16'd1);
    tick(); tick();
    push_v(16'hC000, 16'h1234);
    send_byte(8'h12);
    chk("i16_ov", {15'd0, operands_valid}, 16'd1);
    chk("i16_busy_fall", {15'd0, busy}, 16'd0);
    tick();

    // imm8 signed / zero-extended
    do_start(2'b11, 16'h0011, 16'h0);
    push_v(16'h0011, EXP_FE);
    send_byte(8'hFE);
    do_start(2'b11, 16'h0022, 16'h0);
    push_v(16'h0022, 16'h0005);
    send_byte(8'h05);
    do_start(2'b01, 16'h0033, 16'h0);
    push_v(16'h0033, 16'h0080);
    send_byte(8'h80);
    tick();

    // watchdog abort in WAIT_LO
    do_start(2'b01, 16'hBEEF, 16'h0);
    repeat (7) tick();
    chk("to_busy", {15'd0, busy}, 16'd1);
    chk("to_te_early", {15'd0, timeout_err}, 16'd0);
    push_e(16'hBEEF, 16'h0080);
    tick();
    chk("to_te", {15'd0, timeout_err}, 16'd1);
    chk("to_busy_fall", {15'd0, busy}, 16'd0);
    tick();
    chk("to_te_drop", {15'd0, timeout_err}, 16'd0);
    push_v(16'h1111, 16'h2222);
    do_start(2'b00, 16'h1111, 16'h2222);
    tick();

    // byte on the threshold edge wins
    do_start(2'b01, 16'h3333, 16'h0);
    repeat (7) tick();
    push_v(16'h3333, 16'h005A);
    send_byte(8'h5A);
    chk("thr_te", {15'd0, timeout_err}, 16'd0);
    chk("thr_ov", {15'd0, operands_valid}, 16'd1);
    tick();

    // watchdog abort in WAIT_HI
    do_start(2'b10, 16'h7777, 16'h0);
    send_byte(8'h77);
    repeat (7) tick();
    push_e(16'h7777, 16'h005A);
    tick();
    chk("tohi_te", {15'd0, timeout_err}, 16'd1);
    tick();

    // reset mid-capture drops the pending byte
    do_start(2'b10, 16'hAAAA, 16'h0);
    send_byte(8'h34);
    reset_n = 1'b0; bus_valid = 1'b1; data_bus = 8'h12;
    tick();
    reset_n = 1'b1; bus_valid = 1'b0;
    chk("mrst_in0", ALU_input0, 16'h0000);
    chk("mrst_in1", ALU_input1, 16'h0000);
    chk("mrst_busy", {15'd0, busy}, 16'd0);
    send_byte(8'h12);
    chk("mrst_ov", {15'd0, operands_valid}, 16'd0);
    chk("mrst_busy2", {15'd0, busy}, 16'd0);
    chk("mrst_in1b", ALU_input1, 16'h0000);
    tick();

    // start held through a capture; stray bytes while idle
    start = 1'b1; mode = 2'b10; reg_a = 16'h4444; reg_b = 16'h0;
    tick();
    mode = 2'b00; reg_a = 16'h9999; reg_b = 16'h8888;
    tick();
    chk("hold_busy", {15'd0, busy}, 16'd1);
    send_byte(8'hAA);
    tick();
    push_v(16'h4444, 16'hBBAA);
    bus_valid = 1'b1; data_bus = 8'hBB;
    tick();
    start = 1'b0; bus_valid = 1'b0;
    chk("hold_ov", {15'd0, operands_valid}, 16'd1);
    tick();
    send_byte(8'h99);
    send_byte(8'h99);
    chk("stray_in0", ALU_input0, 16'h4444);
    chk("stray_in1", ALU_input1, 16'hBBAA);
    chk("stray_busy", {15'd0, busy}, 16'd0);

    push_v(16'h5555, 16'h6666);
    do_start(2'b00, 16'h5555, 16'h6666);

    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    tick();
    chk("scoreboard_drained", 16'(q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
